// File: rtl/axi_line_refill_if.sv
// Cache-side request/response and shim-side read channel signals of axi_line_refill.
// The slave modport is the refill block itself; master is the surrounding environment.
interface axi_line_refill_if #(
  parameter int unsigned AxiNumWords = 4,
  parameter int unsigned AxiIdWidth  = 4
);
  logic                           flush_i;
  logic                           req_i;
  logic                           gnt_o;
  logic [63:0]                    addr_i;
  logic                           single_i;
  logic [1:0]                     size_i;
  logic [AxiIdWidth-1:0]          id_i;
  logic                           rsp_valid_o;
  logic                           rsp_ready_i;
  logic [AxiNumWords*64-1:0]      rsp_line_o;
  logic [AxiIdWidth-1:0]          rsp_id_o;
  logic                           rsp_exokay_o;
  logic                           rd_req_o;
  logic                           rd_gnt_i;
  logic [63:0]                    rd_addr_o;
  logic [$clog2(AxiNumWords)-1:0] rd_blen_o;
  logic [1:0]                     rd_size_o;
  logic [AxiIdWidth-1:0]          rd_id_o;
  logic                           rd_lock_o;
  logic                           rd_rdy_o;
  logic                           rd_valid_i;
  logic                           rd_last_i;
  logic [63:0]                    rd_data_i;
  logic [AxiIdWidth-1:0]          rd_id_i;
  logic                           rd_exokay_i;

  modport slave (
    input  flush_i, req_i, addr_i, single_i, size_i, id_i, rsp_ready_i,
           rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_id_i, rd_exokay_i,
    output gnt_o, rsp_valid_o, rsp_line_o, rsp_id_o, rsp_exokay_o,
           rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_lock_o, rd_rdy_o
  );

  modport master (
    output flush_i, req_i, addr_i, single_i, size_i, id_i, rsp_ready_i,
           rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_id_i, rd_exokay_i,
    input  gnt_o, rsp_valid_o, rsp_line_o, rsp_id_o, rsp_exokay_o,
           rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_lock_o, rd_rdy_o
  );
endinterface

// File: rtl/axi_line_refill.sv
// Single-outstanding AXI read front end: issues one read per cache request,
// assembles returned beats into a line buffer and drains the bus on flush.
module axi_line_refill #(
  parameter int unsigned AxiNumWords = 4,
  parameter int unsigned AxiIdWidth  = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  axi_line_refill_if.slave bus
);
  localparam int unsigned     IdxW    = $clog2(AxiNumWords);
  localparam int unsigned     OffW    = $clog2(AxiNumWords * 8);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(AxiNumWords - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_RESP, S_DRAIN} state_e;

  state_e                    r_state, w_state_next;
  logic [AxiNumWords*64-1:0] r_line;
  logic [63:0]               r_addr;
  logic [IdxW-1:0]           r_blen;
  logic [IdxW-1:0]           r_cnt;
  logic [1:0]                r_size;
  logic [AxiIdWidth-1:0]     r_id;
  logic                      r_single;
  logic                      r_exokay;

  logic                      w_gnt, w_rd_req, w_rd_rdy, w_rsp_valid;
  logic                      w_match, w_accept;
  logic [IdxW-1:0]           w_idx;

  assign w_match = bus.rd_valid_i && (bus.rd_id_i == r_id);
  assign w_idx   = r_single ? r_addr[IdxW+2:3] : r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt        = 1'b0;
    w_rd_req     = 1'b0;
    w_rd_rdy     = 1'b0;
    w_rsp_valid  = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_gnt = rst_ni & bus.req_i & ~bus.flush_i;
        if (w_gnt) w_state_next = S_REQ;
      end
      S_REQ: begin
        w_rd_req = 1'b1;
        if (bus.rd_gnt_i)     w_state_next = bus.flush_i ? S_DRAIN : S_DATA;
        else if (bus.flush_i) w_state_next = S_IDLE;
      end
      S_DATA: begin
        w_rd_rdy = 1'b1;
        w_accept = w_match;
        // A flush coinciding with the last beat has nothing left to drain.
        if (w_match && bus.rd_last_i) w_state_next = bus.flush_i ? S_IDLE : S_RESP;
        else if (bus.flush_i)         w_state_next = S_DRAIN;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.flush_i || bus.rsp_ready_i) w_state_next = S_IDLE;
      end
      S_DRAIN: begin
        w_rd_rdy = 1'b1;
        if (w_match && bus.rd_last_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line   <= '0;
      r_addr   <= '0;
      r_blen   <= '0;
      r_cnt    <= '0;
      r_size   <= '0;
      r_id     <= '0;
      r_single <= 1'b0;
      r_exokay <= 1'b0;
    end else if (w_gnt) begin
      r_id     <= bus.id_i;
      r_single <= bus.single_i;
      r_addr   <= bus.single_i ? bus.addr_i : {bus.addr_i[63:OffW], {OffW{1'b0}}};
      r_blen   <= bus.single_i ? '0 : LastIdx;
      r_size   <= bus.single_i ? bus.size_i : 2'd3;
      r_line   <= '0;
      r_exokay <= 1'b1;
      r_cnt    <= '0;
    end else if (w_accept) begin
      for (int unsigned k = 0; k < AxiNumWords; k++) begin
        if (w_idx == IdxW'(k)) r_line[k*64 +: 64] <= bus.rd_data_i;
      end
      r_exokay <= r_exokay & bus.rd_exokay_i;
      // Saturating count: overlong bursts keep overwriting the last word.
      if (!r_single && r_cnt != LastIdx) r_cnt <= r_cnt + IdxW'(1);
    end
  end

  assign bus.gnt_o        = w_gnt;
  assign bus.rd_req_o     = w_rd_req;
  assign bus.rd_rdy_o     = w_rd_rdy;
  assign bus.rsp_valid_o  = w_rsp_valid;
  assign bus.rd_addr_o    = r_addr;
  assign bus.rd_blen_o    = r_blen;
  assign bus.rd_size_o    = r_size;
  assign bus.rd_id_o      = r_id;
  assign bus.rd_lock_o    = 1'b0;
  assign bus.rsp_line_o   = r_line;
  assign bus.rsp_id_o     = r_id;
  assign bus.rsp_exokay_o = r_exokay;
endmodule

// File: tb/tb_axi_line_refill.sv
// Bench for axi_line_refill: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_axi_line_refill;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned LW = N * 64;

  logic        clk    = 1'b0;
  logic        rst_ni = 1'b1;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  axi_line_refill_if #(.AxiNumWords(N), .AxiIdWidth(IW)) bus ();
  axi_line_refill #(.AxiNumWords(N), .AxiIdWidth(IW)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_line(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Transaction-level model: one outstanding request and the words it has collected.
  bit          m_have   = 1'b0;  // request granted, not yet retired
  bit          m_issued = 1'b0;  // shim accepted the address
  bit          m_drain  = 1'b0;  // aborted, sinking remaining beats
  bit          m_done   = 1'b0;  // line assembled, awaiting consumer
  bit          m_single = 1'b0;
  bit          m_exok   = 1'b0;
  logic [63:0] m_addr   = '0;
  logic [1:0]  m_size   = '0;
  logic [IW-1:0] m_id   = '0;
  logic [63:0] m_words [N];
  int unsigned m_nbeats = 0;

  function automatic void model_clear();
    m_have = 1'b0; m_issued = 1'b0; m_drain = 1'b0; m_done = 1'b0;
  endfunction

  function automatic logic [LW-1:0] exp_line();
    logic [LW-1:0] l = '0;
    for (int unsigned k = 0; k < N; k++) l[k*64 +: 64] = m_words[k];
    return l;
  endfunction

  task automatic compare_outputs();
    logic [63:0] ea;
    chk("gnt_o", 64'(bus.gnt_o), 64'(!m_have && bus.req_i && !bus.flush_i));
    chk("rd_req_o", 64'(bus.rd_req_o), 64'(m_have && !m_issued));
    chk("rd_rdy_o", 64'(bus.rd_rdy_o), 64'(m_have && m_issued && !m_done));
    chk("rsp_valid_o", 64'(bus.rsp_valid_o), 64'(m_done));
    chk("rd_lock_o", 64'(bus.rd_lock_o), 64'(0));
    if (m_have && !m_issued) begin
      ea = m_single ? m_addr : (m_addr & ~64'(N * 8 - 1));
      chk("rd_addr_o", bus.rd_addr_o, ea);
      chk("rd_blen_o", 64'(bus.rd_blen_o), m_single ? 64'(0) : 64'(N - 1));
      chk("rd_size_o", 64'(bus.rd_size_o), m_single ? 64'(m_size) : 64'(3));
      chk("rd_id_o", 64'(bus.rd_id_o), 64'(m_id));
    end
    if (m_done) begin
      chk_line("rsp_line_o", bus.rsp_line_o, exp_line());
      chk("rsp_id_o", 64'(bus.rsp_id_o), 64'(m_id));
      chk("rsp_exokay_o", 64'(bus.rsp_exokay_o), 64'(m_exok));
    end
  endtask

  task automatic model_step();
    bit          match;
    int unsigned idx;
    if (!m_have) begin
      if (bus.req_i && !bus.flush_i) begin
        m_have = 1'b1; m_issued = 1'b0; m_drain = 1'b0; m_done = 1'b0;
        m_addr = bus.addr_i; m_single = bus.single_i; m_size = bus.size_i; m_id = bus.id_i;
        for (int unsigned k = 0; k < N; k++) m_words[k] = '0;
        m_nbeats = 0; m_exok = 1'b1;
      end
    end else if (!m_issued) begin
      if (bus.rd_gnt_i) begin
        m_issued = 1'b1; m_drain = bus.flush_i;
      end else if (bus.flush_i) model_clear();
    end else if (m_done) begin
      if (bus.flush_i || bus.rsp_ready_i) model_clear();
    end else begin
      match = bus.rd_valid_i && (bus.rd_id_i == m_id);
      if (m_drain) begin
        if (match && bus.rd_last_i) model_clear();
      end else begin
        if (match) begin
          idx = m_single ? int'((m_addr / 8) % 64'(N)) : ((m_nbeats < N) ? m_nbeats : N - 1);
          m_words[idx] = bus.rd_data_i;
          m_nbeats++;
          m_exok = m_exok & bus.rd_exokay_i;
        end
        if (match && bus.rd_last_i) begin
          if (bus.flush_i) model_clear();
          else m_done = 1'b1;
        end else if (bus.flush_i) m_drain = 1'b1;
      end
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_ni) model_clear();
      compare_outputs();
      if (rst_ni) model_step();
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.flush_i = 1'b0; bus.req_i = 1'b0; bus.addr_i = '0; bus.single_i = 1'b0;
    bus.size_i = '0; bus.id_i = '0; bus.rsp_ready_i = 1'b0; bus.rd_gnt_i = 1'b0;
    bus.rd_valid_i = 1'b0; bus.rd_last_i = 1'b0; bus.rd_data_i = '0;
    bus.rd_id_i = '0; bus.rd_exokay_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(bus.gnt_o), 64'(0));
    chk({tag, "_rd_req"}, 64'(bus.rd_req_o), 64'(0));
    chk({tag, "_rd_rdy"}, 64'(bus.rd_rdy_o), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(0));
    chk({tag, "_rd_addr"}, bus.rd_addr_o, 64'(0));
    chk({tag, "_rd_blen"}, 64'(bus.rd_blen_o), 64'(0));
    chk({tag, "_rd_size"}, 64'(bus.rd_size_o), 64'(0));
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id_o), 64'(0));
    chk({tag, "_rsp_exokay"}, 64'(bus.rsp_exokay_o), 64'(0));
    chk_line({tag, "_rsp_line"}, bus.rsp_line_o, '0);
  endtask

  task automatic issue(input logic [63:0] a, input bit single, input logic [1:0] sz,
                       input logic [IW-1:0] id);
    bus.req_i = 1'b1; bus.addr_i = a; bus.single_i = single; bus.size_i = sz; bus.id_i = id;
    #1 chk("issue_gnt", 64'(bus.gnt_o), 64'(1));
    tick();
    bus.req_i = 1'b0;
  endtask

  task automatic shim_grant();
    bus.rd_gnt_i = 1'b1;
    tick();
    bus.rd_gnt_i = 1'b0;
  endtask

  task automatic beat(input logic [IW-1:0] id, input logic [63:0] d, input bit last, input bit ex);
    bus.rd_valid_i = 1'b1; bus.rd_id_i = id; bus.rd_data_i = d;
    bus.rd_last_i = last; bus.rd_exokay_i = ex;
    tick();
    bus.rd_valid_i = 1'b0; bus.rd_last_i = 1'b0;
  endtask

  initial begin : stimulus
    clr_inputs();
    #1 rst_ni = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // Line refill, id 3
    issue(64'h1000_0038, 1'b0, 2'd0, 4'd3);
    chk("line_rd_req", 64'(bus.rd_req_o), 64'(1));
    chk("line_rd_addr", bus.rd_addr_o, 64'h1000_0020);
    chk("line_blen", 64'(bus.rd_blen_o), 64'(3));
    chk("line_size", 64'(bus.rd_size_o), 64'(3));
    shim_grant();
    for (int unsigned k = 0; k < 4; k++) beat(4'd3, 64'hA0 + 64'(k), k == 3, 1'b1);
    chk("line_valid", 64'(bus.rsp_valid_o), 64'(1));
    chk_line("line_data", bus.rsp_line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    chk("line_id", 64'(bus.rsp_id_o), 64'(3));
    chk("line_exokay", 64'(bus.rsp_exokay_o), 64'(1));
    bus.rsp_ready_i = 1'b1; tick(); bus.rsp_ready_i = 1'b0;
    chk("line_retired", 64'(bus.rsp_valid_o), 64'(0));

    // Single-word read lands at word 2
    issue(64'h2010, 1'b1, 2'd2, 4'd1);
    chk("single_addr", bus.rd_addr_o, 64'h2010);
    chk("single_blen", 64'(bus.rd_blen_o), 64'(0));
    chk("single_size", 64'(bus.rd_size_o), 64'(2));
    shim_grant();
    beat(4'd1, 64'hDEAD, 1'b1, 1'b1);
    chk("single_valid", 64'(bus.rsp_valid_o), 64'(1));
    chk_line("single_data", bus.rsp_line_o, {64'h0, 64'hDEAD, 64'h0, 64'h0});
    chk("single_exokay", 64'(bus.rsp_exokay_o), 64'(1));
    bus.rsp_ready_i = 1'b1; tick(); bus.rsp_ready_i = 1'b0;

    // Foreign ID interleaved, one beat without exokay
    issue(64'h3000, 1'b0, 2'd0, 4'd3);
    shim_grant();
    beat(4'd3, 64'hB0, 1'b0, 1'b1);
    beat(4'd5, 64'hBAD, 1'b1, 1'b1);
    chk("foreign_ignored", 64'(bus.rsp_valid_o), 64'(0));
    beat(4'd3, 64'hB1, 1'b0, 1'b0);
    beat(4'd3, 64'hB2, 1'b0, 1'b1);
    beat(4'd3, 64'hB3, 1'b1, 1'b1);
    chk_line("foreign_data", bus.rsp_line_o, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
    chk("foreign_exokay", 64'(bus.rsp_exokay_o), 64'(0));
    bus.rsp_ready_i = 1'b1; tick(); bus.rsp_ready_i = 1'b0;

    // Flush after two beats, drain the rest
    issue(64'h4000, 1'b0, 2'd0, 4'd2);
    shim_grant();
    beat(4'd2, 64'hC0, 1'b0, 1'b1);
    beat(4'd2, 64'hC1, 1'b0, 1'b1);
    bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
    chk("drain_rdy", 64'(bus.rd_rdy_o), 64'(1));
    beat(4'd2, 64'hC2, 1'b0, 1'b1);
    chk("drain_rdy2", 64'(bus.rd_rdy_o), 64'(1));
    chk("drain_novalid", 64'(bus.rsp_valid_o), 64'(0));
    beat(4'd2, 64'hC3, 1'b1, 1'b1);
    chk("drain_done_rdy", 64'(bus.rd_rdy_o), 64'(0));
    chk("drain_done_valid", 64'(bus.rsp_valid_o), 64'(0));
    issue(64'h5000, 1'b0, 2'd0, 4'd7);

    // Flush in REQ without shim grant drops the request
    chk("reqflush_pre", 64'(bus.rd_req_o), 64'(1));
    bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
    chk("reqflush_req", 64'(bus.rd_req_o), 64'(0));
    chk("reqflush_rdy", 64'(bus.rd_rdy_o), 64'(0));
    tick();
    chk("reqflush_valid", 64'(bus.rsp_valid_o), 64'(0));

    // Response backpressure; next request waits, then is granted right after handshake
    issue(64'h6008, 1'b1, 2'd3, 4'd4);
    shim_grant();
    beat(4'd4, 64'h1234, 1'b1, 1'b1);
    bus.req_i = 1'b1; bus.addr_i = 64'h7000; bus.single_i = 1'b0; bus.id_i = 4'd6;
    for (int unsigned c = 0; c < 5; c++) begin
      #1;
      chk("bp_gnt", 64'(bus.gnt_o), 64'(0));
      chk("bp_valid", 64'(bus.rsp_valid_o), 64'(1));
      chk_line("bp_line", bus.rsp_line_o, {64'h0, 64'h0, 64'h1234, 64'h0});
      chk("bp_id", 64'(bus.rsp_id_o), 64'(4));
      tick();
    end
    bus.rsp_ready_i = 1'b1; tick(); bus.rsp_ready_i = 1'b0;
    #1 chk("b2b_gnt", 64'(bus.gnt_o), 64'(1));
    tick();
    bus.req_i = 1'b0;
    bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;

    // Reset mid-DATA, then stray beats
    issue(64'h8000, 1'b0, 2'd0, 4'd9);
    shim_grant();
    beat(4'd9, 64'hE0, 1'b0, 1'b1);
    rst_ni = 1'b0;
    #1 chk_all_zero("midrst");
    tick(); tick();
    rst_ni = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      bus.rd_valid_i = 1'b1; bus.rd_id_i = 4'd9; bus.rd_last_i = (c == 2); bus.rd_data_i = 64'hF0;
      #1;
      chk("stray_rdy", 64'(bus.rd_rdy_o), 64'(0));
      chk("stray_valid", 64'(bus.rsp_valid_o), 64'(0));
      tick();
    end
    clr_inputs();
    tick();

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        clr_inputs();
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
      end
      bus.req_i       = 1'($urandom_range(0, 1));
      bus.addr_i      = {$urandom, $urandom};
      bus.single_i    = 1'($urandom_range(0, 1));
      bus.size_i      = 2'($urandom_range(0, 3));
      bus.id_i        = IW'($urandom_range(0, 3));
      bus.flush_i     = ($urandom_range(0, 29) == 0);
      bus.rd_gnt_i    = 1'($urandom_range(0, 1));
      bus.rd_valid_i  = ($urandom_range(0, 2) != 0);
      bus.rd_id_i     = ($urandom_range(0, 4) != 0) ? bus.rd_id_o : IW'($urandom_range(0, 15));
      bus.rd_last_i   = ($urandom_range(0, 3) == 0);
      bus.rd_data_i   = {$urandom, $urandom};
      bus.rd_exokay_i = ($urandom_range(0, 7) != 0);
      bus.rsp_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    clr_inputs();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
